uart_msg_tx: RTL
================

UART_MSG_TX -- requirements
Module: uart_msg_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 10417, meaning clk cycles per serial bit (≥2).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (5..8).
REQ-003 The block SHALL have parameter PARITY, default 0, meaning 0 none, 1 even, 2 odd.
REQ-004 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (1 or 2).
REQ-005 The block SHALL have parameter MSG_LEN, default 95, meaning characters per message (1..256).
REQ-006 The block SHALL have parameter GAP_CLKS, default 0, meaning idle-high clk cycles between characters.
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 start  input  1  one-cycle request to send one whole message.
REQ-010 rom_ren  output  1  one-cycle read strobe to external character ROM.
REQ-011 rom_addr  output  8  character index, 0..MSG_LEN-1.
REQ-012 rom_data  input  8  ROM output, valid the cycle after rom_ren.
REQ-013 TxD  output  1  serial line, idle high, LSB first.
REQ-014 tx_busy  output  1  high from the cycle after accepted start until return to IDLE.
REQ-015 msg_done  output  1  one-cycle pulse after the last stop bit of the last character.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, LOAD, START, DATA, PAR, STOP, GAP.
REQ-017 IDLE: start=1 -> FETCH, rom_addr=0; start in any other state SHALL be ignored (no queuing).
REQ-018 FETCH: rom_ren=1 for exactly one cycle -> LOAD.
REQ-019 LOAD: shift register <= rom_data[DATA_BITS-1:0]; parity bit computed; -> START; TxD goes low on the next edge.
REQ-020 Baud counter SHALL restart at 0 on entry to START (frame-aligned, not free-running); each bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-021 DATA: DATA_BITS bits, LSB first, bit counter 0..DATA_BITS-1; then PAR if PARITY!=0, else STOP.
REQ-022 PAR bit SHALL be XOR of data bits (even) or its inverse (odd).
REQ-023 STOP: TxD=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-024 After STOP: if rom_addr==MSG_LEN-1 -> IDLE with msg_done=1 for one cycle, rom_addr held; else rom_addr+1 and -> GAP (GAP_CLKS>0) or FETCH (GAP_CLKS=0).
REQ-025 GAP: TxD=1 for exactly GAP_CLKS cycles -> FETCH.
REQ-026 rom_addr SHALL wrap to 0 only via a new start; never exceed MSG_LEN-1.
REQ-027 Frame length SHALL be (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles; TxD high in IDLE, FETCH, LOAD, GAP.
REQ-028 start coincident with msg_done SHALL be ignored; start one cycle later SHALL be accepted.

Reset
REQ-029 rst=1 SHALL force on the next edge: state IDLE, TxD=1, tx_busy=0, msg_done=0, rom_ren=0, rom_addr=0, all counters 0.
REQ-030 rst mid-frame SHALL abort the message with no further line activity; start SHALL be ignored while rst=1.

Structure
REQ-031 Shared package SHALL hold the FSM state encoding and parity-mode constants (PAR_NONE/PAR_EVEN/PAR_ODD).
REQ-032 Baud/bit timing SHALL be one sub-module, uart_bit_timer (clear input, one-cycle bit_end output at count CLKS_PER_BIT-1).
REQ-033 Parameter legality (ranges above) SHALL be checked at elaboration.

Verification (CLKS_PER_BIT=4 unless noted; ROM model 1-cycle latency, holds "ABC")
REQ-034 MSG_LEN=1, 8N1, start -> TxD 0,1,0,0,0,0,0,1,0,1 per 4 cycles (0x41), msg_done 40 cycles after first low.
REQ-035 MSG_LEN=3, PARITY=1, STOP_BITS=2, GAP_CLKS=5 -> frames 0x41/0x42/0x43 with parity 0,0,1; 5 high cycles between frames; one msg_done.
REQ-036 DATA_BITS=7, PARITY=2, send 0x41 -> 7 data bits then parity 1; frame 40 cycles.
REQ-037 start pulses during tx_busy and on msg_done cycle -> ignored; start next cycle -> new message from rom_addr=0.
REQ-038 rst asserted mid DATA -> next edge TxD=1, tx_busy=0, rom_addr=0; no further TxD transitions until new start.
REQ-039 CLKS_PER_BIT=10417, 8N1, one char -> each bit exactly 10417 cycles, frame 104170 cycles.

Source files
------------

// File: rtl/uart_msg_tx_pkg.sv
// Shared definitions for the message UART transmitter: FSM encoding,
// parity-mode constants and the parity helper.
package uart_msg_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_PAR   = 3'd5,
    ST_STOP  = 3'd6,
    ST_GAP   = 3'd7
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Parity over the low nbits of data; inverted for odd mode.
  function automatic logic calc_parity(input logic [7:0] data, input int nbits,
                                       input logic [1:0] mode);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < nbits) p = p ^ data[i];
    end
    return (mode == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_msg_tx_bit_timer.sv
// Frame-aligned baud counter: held at zero by clear, pulses bit_end on the
// last cycle of every bit period.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt_r;

  assign bit_end = (cnt_r == CW'(CLKS_PER_BIT - 1));

  // Count cycles within the current bit, restarting at every bit boundary.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_r <= '0;
    end else if (bit_end) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

endmodule

// File: rtl/uart_msg_tx.sv
// Sends a MSG_LEN-character message fetched from an external 1-cycle ROM as
// UART frames, one message per accepted start pulse.
module uart_msg_tx
  import uart_msg_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int MSG_LEN      = 95,
  parameter int GAP_CLKS     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       rom_ren,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       TxD,
  output logic       tx_busy,
  output logic       msg_done
);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_msg_tx: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_db
    $error("uart_msg_tx: DATA_BITS must be 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_msg_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("uart_msg_tx: STOP_BITS must be 1 or 2");
  end
  if (MSG_LEN < 1 || MSG_LEN > 256) begin : g_bad_len
    $error("uart_msg_tx: MSG_LEN must be 1..256");
  end
  if (GAP_CLKS < 0) begin : g_bad_gap
    $error("uart_msg_tx: GAP_CLKS must be non-negative");
  end

  localparam logic [1:0] PAR_MODE  = 2'(PARITY);
  localparam logic [7:0] LAST_ADDR = 8'(MSG_LEN - 1);
  localparam int         GW        = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  state_t               state_r;
  logic [DATA_BITS-1:0] shreg_r;
  logic                 par_r;
  logic [2:0]           bit_cnt_r;
  logic                 stop_cnt_r;
  logic [GW-1:0]        gap_cnt_r;
  logic                 timer_clear_s;
  logic                 bit_end_s;

  // The baud counter only runs while a frame is on the line.
  assign timer_clear_s = !(state_r inside {ST_START, ST_DATA, ST_PAR, ST_STOP});

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear_s),
    .bit_end (bit_end_s)
  );

  // Message sequencer; every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      shreg_r    <= '0;
      par_r      <= 1'b0;
      bit_cnt_r  <= 3'd0;
      stop_cnt_r <= 1'b0;
      gap_cnt_r  <= '0;
      rom_ren    <= 1'b0;
      rom_addr   <= 8'd0;
      TxD        <= 1'b1;
      tx_busy    <= 1'b0;
      msg_done   <= 1'b0;
    end else begin
      rom_ren  <= 1'b0;
      msg_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          TxD <= 1'b1;
          // A start coinciding with the completion pulse is dropped.
          if (start && !msg_done) begin
            state_r  <= ST_FETCH;
            rom_addr <= 8'd0;
            rom_ren  <= 1'b1;
            tx_busy  <= 1'b1;
          end
        end
        ST_FETCH: state_r <= ST_LOAD;
        ST_LOAD: begin
          shreg_r <= rom_data[DATA_BITS-1:0];
          par_r   <= calc_parity(rom_data, DATA_BITS, PAR_MODE);
          TxD     <= 1'b0;
          state_r <= ST_START;
        end
        ST_START: begin
          if (bit_end_s) begin
            TxD       <= shreg_r[0];
            shreg_r   <= shreg_r >> 1;
            bit_cnt_r <= 3'd0;
            state_r   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end_s) begin
            if (bit_cnt_r == 3'(DATA_BITS - 1)) begin
              if (PAR_MODE != PAR_NONE) begin
                TxD     <= par_r;
                state_r <= ST_PAR;
              end else begin
                TxD        <= 1'b1;
                stop_cnt_r <= 1'b0;
                state_r    <= ST_STOP;
              end
            end else begin
              TxD       <= shreg_r[0];
              shreg_r   <= shreg_r >> 1;
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
        end
        ST_PAR: begin
          if (bit_end_s) begin
            TxD        <= 1'b1;
            stop_cnt_r <= 1'b0;
            state_r    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_end_s) begin
            if (stop_cnt_r == 1'(STOP_BITS - 1)) begin
              if (rom_addr == LAST_ADDR) begin
                msg_done <= 1'b1;
                tx_busy  <= 1'b0;
                state_r  <= ST_IDLE;
              end else begin
                rom_addr <= rom_addr + 8'd1;
                if (GAP_CLKS > 0) begin
                  gap_cnt_r <= '0;
                  state_r   <= ST_GAP;
                end else begin
                  rom_ren <= 1'b1;
                  state_r <= ST_FETCH;
                end
              end
            end else begin
              stop_cnt_r <= stop_cnt_r + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GW'(GAP_CLKS - 1)) begin
            rom_ren <= 1'b1;
            state_r <= ST_FETCH;
          end else begin
            gap_cnt_r <= gap_cnt_r + GW'(1);
          end
        end
        default: begin
          TxD     <= 1'b1;
          tx_busy <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
